id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with load-use hazard detection for the 16-entry register-file pipeline.
- Captures decoded operands and control from ID and presents them to EX.
- Its idex_rs, idex_rt, idex_rd and idex_reg_write outputs feed the EX-stage forwarding unit directly.
- Inserts one bubble on a load-use hazard and stalls IF/ID for that cycle. Also handles branch flush and a global memory hold.

Parameters:
- DATA_W, 16, operand/immediate width
- REG_AW, 4, register-index width; register 0 is hardwired zero
- ALUOP_W, 4, ALU opcode width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW each  decoded register indices
- id_uses_rt  in  1  instruction actually reads rt
- id_rdata1, id_rdata2, id_imm  in  DATA_W each  register-file read data and immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  in  1 each  control bits
- id_alu_op  in  ALUOP_W  ALU opcode
- ex_flush  in  1  branch taken in EX; kill the instruction in ID
- mem_hold  in  1  memory stage busy; freeze the whole stage
- idex_valid, idex_rs, idex_rt, idex_rd, idex_rdata1, idex_rdata2, idex_imm, idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg, idex_alu_src, idex_alu_op  out  (widths as above)  registered copies
- ifid_stall  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_cnt  out  16  bubbles inserted (STALL_COUNT_EN only)

Behaviour:
- Reset (rst_n low, asynchronous): all idex_* outputs = 0 and state = RUN. ifid_stall = 0 and bubble_cnt = 0 while reset is asserted.
- Hazard (combinational) is true when all of the following hold:
  - idex_valid && idex_mem_read
  - idex_rd != 0
  - id_valid
  - (idex_rd == id_rs) or (id_uses_rt && idex_rd == id_rt)
- ifid_stall = hazard && !ex_flush && state==RUN, OR mem_hold.
- State machine:
  - RUN: on hazard (no flush, no hold), go to BUBBLE.
  - BUBBLE: lasts exactly one cycle, then returns to RUN. The loaded instruction has advanced to EX/MEM, so the next cycle sees no hazard with that load.
  - Hold freezes the state.
- Per-edge priority, highest first:
  1. mem_hold: every register and the state keep their values. A flush or hazard arriving during hold takes effect on the first cycle hold is low.
  2. ex_flush: load a bubble — idex_valid=0 and all control bits 0 (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op). Data/index fields are don't-care but are written 0. State goes to RUN.
  3. hazard in RUN: load a bubble as in 2; state goes to BUBBLE.
  4. otherwise: load all id_* fields. If !id_valid, control bits are forced 0.
- Bubbles never assert write enables, so downstream forwarding can never match them.
- Latency: 1 cycle from ID to EX. A load-use pair costs exactly 1 extra cycle.
- Register 0 destination never triggers a stall.
- Back-to-back loads to the same rd are each checked independently.

Optional Feature:
- Macro: ID_EX_STAGE_STALL_COUNT_EN.
- Defined: bubble_cnt increments by 1 on every edge that loads a hazard bubble (not flush bubbles, not held cycles). Saturates at 16'hFFFF. Reset to 0.
- Undefined: the bubble_cnt port is absent and no counter logic exists.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - REG_AW, DATA_W, ALUOP_W
  - ZERO_REG = 4'd0
  - a packed control-bundle typedef (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op)
  - the state enum {RUN, BUBBLE}
- One sub-module: load_use_detect, purely combinational; computes hazard from the idex_* and id_* index fields.

Test Plan:
- Load r3, then add r5=r3+r1 (id_rs=3): ifid_stall=1 for one cycle; the next idex has valid=0 and all control bits 0; the cycle after, idex_rs=3 with the add's controls; bubble_cnt=1.
- Load r3, then an instruction using rt=3 with id_uses_rt=0: no stall; idex loads directly.
- Load r0, then add using rs=0: no stall, no bubble.
- Hazard cycle coincident with ex_flush=1: ifid_stall=0; idex becomes a bubble; state stays RUN; bubble_cnt unchanged.
- mem_hold=1 for 3 cycles with a pending hazard: all idex_* outputs constant and ifid_stall=1 throughout. After release, exactly one bubble, then the dependent instruction.
- Deassert rst_n mid-BUBBLE: outputs go to 0 immediately (asynchronously). After release, the first id_valid instruction loads normally.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the 16-entry register-file pipeline:
// widths, the hardwired zero register, the EX control bundle and ID/EX state.
package cpu_pipe_pkg;

  localparam int REG_AW  = 4;
  localparam int DATA_W  = 16;
  localparam int ALUOP_W = 4;

  localparam logic [REG_AW-1:0] ZERO_REG = 4'd0;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  typedef enum logic {RUN, BUBBLE} state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: a load in EX whose destination is
// read by the instruction currently in ID.
module load_use_detect #(
  parameter int REG_AW = 4
) (
  input  logic              idex_valid,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hazard
);
  import cpu_pipe_pkg::*;

  logic rs_match;
  logic rt_match;

  assign rs_match = (idex_rd == id_rs);
  assign rt_match = id_uses_rt && (idex_rd == id_rt);
  // Writes to the zero register are discarded, so they can never be a source.
  assign hazard   = idex_valid && idex_mem_read && (idex_rd != ZERO_REG) &&
                    id_valid && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// memory hold. Optional bubble counter enabled by ID_EX_STAGE_STALL_COUNT_EN.
module id_ex_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_uses_rt,
  input  logic [DATA_W-1:0]  id_rdata1,
  input  logic [DATA_W-1:0]  id_rdata2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               ex_flush,
  input  logic               mem_hold,
  output logic               idex_valid,
  output logic [REG_AW-1:0]  idex_rs,
  output logic [REG_AW-1:0]  idex_rt,
  output logic [REG_AW-1:0]  idex_rd,
  output logic [DATA_W-1:0]  idex_rdata1,
  output logic [DATA_W-1:0]  idex_rdata2,
  output logic [DATA_W-1:0]  idex_imm,
  output logic               idex_reg_write,
  output logic               idex_mem_read,
  output logic               idex_mem_write,
  output logic               idex_mem_to_reg,
  output logic               idex_alu_src,
  output logic [ALUOP_W-1:0] idex_alu_op,
  output logic               ifid_stall
`ifdef ID_EX_STAGE_STALL_COUNT_EN
  ,
  output logic [15:0]        bubble_cnt
`endif
);
  import cpu_pipe_pkg::*;

  state_t state_p1;
  ctrl_t  id_ctrl;
  ctrl_t  ctrl_p1;
  logic   hazard;
  logic   hazard_bubble;

  load_use_detect #(.REG_AW(REG_AW)) u_detect (
    .idex_valid    (idex_valid),
    .idex_mem_read (ctrl_p1.mem_read),
    .idex_rd       (idex_rd),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .hazard        (hazard)
  );

  // A non-instruction in ID must never carry live write enables into EX.
  assign id_ctrl = id_valid ? ctrl_t'{id_reg_write, id_mem_read, id_mem_write,
                                      id_mem_to_reg, id_alu_src, id_alu_op}
                            : '0;

  assign hazard_bubble = hazard && (state_p1 == RUN);
  assign ifid_stall    = rst_n && ((hazard_bubble && !ex_flush) || mem_hold);

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1    <= RUN;
      idex_valid  <= 1'b0;
      idex_rs     <= '0;
      idex_rt     <= '0;
      idex_rd     <= '0;
      idex_rdata1 <= '0;
      idex_rdata2 <= '0;
      idex_imm    <= '0;
      ctrl_p1     <= '0;
    end else if (!mem_hold) begin
      if (ex_flush || hazard_bubble) begin
        state_p1    <= ex_flush ? RUN : BUBBLE;
        idex_valid  <= 1'b0;
        idex_rs     <= '0;
        idex_rt     <= '0;
        idex_rd     <= '0;
        idex_rdata1 <= '0;
        idex_rdata2 <= '0;
        idex_imm    <= '0;
        ctrl_p1     <= '0;
      end else begin
        state_p1    <= RUN;
        idex_valid  <= id_valid;
        idex_rs     <= id_rs;
        idex_rt     <= id_rt;
        idex_rd     <= id_rd;
        idex_rdata1 <= id_rdata1;
        idex_rdata2 <= id_rdata2;
        idex_imm    <= id_imm;
        ctrl_p1     <= id_ctrl;
      end
    end
  end

  assign idex_reg_write  = ctrl_p1.reg_write;
  assign idex_mem_read   = ctrl_p1.mem_read;
  assign idex_mem_write  = ctrl_p1.mem_write;
  assign idex_mem_to_reg = ctrl_p1.mem_to_reg;
  assign idex_alu_src    = ctrl_p1.alu_src;
  assign idex_alu_op     = ctrl_p1.alu_op;

`ifdef ID_EX_STAGE_STALL_COUNT_EN
  // Counts only hazard bubbles actually loaded; flushes and held edges excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!mem_hold && !ex_flush && hazard_bubble && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed load-use/flush/hold/reset
// scenarios plus randomized traffic against a behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rt;
  logic [3:0]  id_rs, id_rt, id_rd, id_alu_op;
  logic [15:0] id_rdata1, id_rdata2, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic        ex_flush, mem_hold;
  logic        idex_valid;
  logic [3:0]  idex_rs, idex_rt, idex_rd, idex_alu_op;
  logic [15:0] idex_rdata1, idex_rdata2, idex_imm;
  logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg, idex_alu_src;
  logic        ifid_stall;
`ifdef ID_EX_STAGE_STALL_COUNT_EN
  logic [15:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .ex_flush(ex_flush), .mem_hold(mem_hold),
    .idex_valid(idex_valid), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2), .idex_imm(idex_imm),
    .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .idex_mem_write(idex_mem_write), .idex_mem_to_reg(idex_mem_to_reg),
    .idex_alu_src(idex_alu_src), .idex_alu_op(idex_alu_op),
    .ifid_stall(ifid_stall)
`ifdef ID_EX_STAGE_STALL_COUNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  rs, rt, rd;
    logic [15:0] d1, d2, imm;
    logic        rw, mr, mw, m2r, as;
    logic [3:0]  op;
  } ex_t;

  ex_t obs;
  assign obs = {idex_valid, idex_rs, idex_rt, idex_rd, idex_rdata1, idex_rdata2, idex_imm,
                idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg,
                idex_alu_src, idex_alu_op};

  int errors = 0;
  int checks = 0;

  // Model: what EX should hold, and how many hazard bubbles should exist.
  ex_t         m;
  int unsigned mcnt;
  logic        m_stall, s_stall;

  function automatic ex_t id_now();
    ex_t e;
    e.valid = id_valid;
    e.rs = id_rs; e.rt = id_rt; e.rd = id_rd;
    e.d1 = id_rdata1; e.d2 = id_rdata2; e.imm = id_imm;
    e.rw = id_valid & id_reg_write;  e.mr = id_valid & id_mem_read;
    e.mw = id_valid & id_mem_write;  e.m2r = id_valid & id_mem_to_reg;
    e.as = id_valid & id_alu_src;    e.op = id_valid ? id_alu_op : 4'd0;
    return e;
  endfunction

  // A bubble in EX is never a load, so a dependent instruction stalls once.
  function automatic logic m_hazard();
    return m.valid && m.mr && (m.rd != 4'd0) && id_valid &&
           ((m.rd == id_rs) || (id_uses_rt && (m.rd == id_rt)));
  endfunction

  task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic ut, input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ut;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    id_mem_to_reg = mr; id_alu_src = mr | ~ut; id_alu_op = 4'($urandom_range(1, 15));
    id_rdata1 = 16'($urandom); id_rdata2 = 16'($urandom); id_imm = 16'($urandom);
  endtask

  // One clock: sample the stall before the edge, advance the model at the edge.
  task automatic tick();
    @(negedge clk);
    #1;
    m_stall = rst_n && ((m_hazard() && !ex_flush) || mem_hold);
    s_stall = ifid_stall;
    @(posedge clk);
    if (rst_n && !mem_hold) begin
      if (ex_flush) m = '0;
      else if (m_hazard()) begin
        m = '0;
        if (mcnt < 32'hFFFF) mcnt++;
      end else m = id_now();
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_hold = 1'b1; ex_flush = 1'b0;
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    m = '0; mcnt = 0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
    checks++;
    if (ifid_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", ifid_stall); end
`ifdef ID_EX_STAGE_STALL_COUNT_EN
    checks++;
    if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1; mem_hold = 1'b0;
  endtask

  task automatic test_load_use();
    set_id(1'b1, 4'd1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd3, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (s_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", s_stall); end
    checks++;
    if ({idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg,
         idex_alu_src, idex_alu_op} !== 10'd0) begin
      errors++; $display("FAIL lu_bubble: got valid=%b rw=%b mr=%b op=%h want all 0",
                         idex_valid, idex_reg_write, idex_mem_read, idex_alu_op);
    end
    tick();
    checks++;
    if (s_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", s_stall); end
    checks++;
    if (idex_valid !== 1'b1 || idex_rs !== 4'd3 || idex_reg_write !== 1'b1 || idex_mem_read !== 1'b0)
    begin errors++; $display("FAIL lu_dependent: got v=%b rs=%0d rw=%b mr=%b want 1 3 1 0",
                             idex_valid, idex_rs, idex_reg_write, idex_mem_read); end
    checks++;
    if (obs !== m) begin errors++; $display("FAIL lu_fields: got %h want %h", obs, m); end
`ifdef ID_EX_STAGE_STALL_COUNT_EN
    checks++;
    if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", bubble_cnt); end
`endif
  endtask

  task automatic test_rt_unused();
    set_id(1'b1, 4'd1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd1, 4'd3, 4'd6, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (s_stall !== 1'b0) begin errors++; $display("FAIL rt_unused_stall: got %b want 0", s_stall); end
    checks++;
    if (idex_valid !== 1'b1 || idex_rt !== 4'd3 || obs !== m)
    begin errors++; $display("FAIL rt_unused_load: got %h want %h", obs, m); end
  endtask

  task automatic test_r0();
    set_id(1'b1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (s_stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b want 0", s_stall); end
    checks++;
    if (idex_valid !== 1'b1 || idex_rd !== 4'd7 || obs !== m)
    begin errors++; $display("FAIL r0_load: got %h want %h", obs, m); end
  endtask

  task automatic test_flush_hazard();
    int unsigned cnt0;
    set_id(1'b1, 4'd1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1);
    tick();
    cnt0 = mcnt;
    set_id(1'b1, 4'd3, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    checks++;
    if (s_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", s_stall); end
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL flush_bubble: got %h want 0", obs); end
`ifdef ID_EX_STAGE_STALL_COUNT_EN
    checks++;
    if (bubble_cnt !== 16'(cnt0)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", bubble_cnt, cnt0); end
`endif
    set_id(1'b1, 4'd3, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (s_stall !== 1'b0 || idex_valid !== 1'b1 || obs !== m)
    begin errors++; $display("FAIL flush_next: stall=%b got %h want %h", s_stall, obs, m); end
  endtask

  task automatic test_hold();
    ex_t snap;
    set_id(1'b1, 4'd1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1);
    tick();
    snap = obs;
    set_id(1'b1, 4'd2, 4'd3, 4'd8, 1'b1, 1'b1, 1'b0);
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_stall !== 1'b1 || obs !== snap)
      begin errors++; $display("FAIL hold_%0d: stall=%b got %h want %h", i, s_stall, obs, snap); end
    end
    mem_hold = 1'b0;
    tick();
    checks++;
    if (s_stall !== 1'b1 || idex_valid !== 1'b0 || idex_reg_write !== 1'b0)
    begin errors++; $display("FAIL hold_bubble: stall=%b valid=%b want 1 0", s_stall, idex_valid); end
    tick();
    checks++;
    if (s_stall !== 1'b0 || idex_rt !== 4'd3 || idex_valid !== 1'b1 || obs !== m)
    begin errors++; $display("FAIL hold_dependent: stall=%b got %h want %h", s_stall, obs, m); end
  endtask

  task automatic test_reset_mid_bubble();
    set_id(1'b1, 4'd4, 4'd5, 4'd9, 1'b1, 1'b1, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL async_reset: got %h want 0", obs); end
    @(negedge clk);
    rst_n = 1'b1; m = '0; mcnt = 0;
    set_id(1'b1, 4'd1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd3, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    mem_hold = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0 || ifid_stall !== 1'b0)
    begin errors++; $display("FAIL bubble_reset: stall=%b got %h want 0", ifid_stall, obs); end
`ifdef ID_EX_STAGE_STALL_COUNT_EN
    checks++;
    if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL bubble_reset_cnt: got %0d want 0", bubble_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1; mem_hold = 1'b0; m = '0; mcnt = 0;
    set_id(1'b1, 4'd6, 4'd7, 4'd2, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (idex_valid !== 1'b1 || idex_rd !== 4'd2 || obs !== m)
    begin errors++; $display("FAIL post_reset_load: got %h want %h", obs, m); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom_range(0, 5) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
      id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom); id_alu_src = 1'($urandom);
      ex_flush = ($urandom_range(0, 9) == 0);
      mem_hold = ($urandom_range(0, 6) == 0);
      tick();
      checks++;
      if (s_stall !== m_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, s_stall, m_stall); end
      checks++;
      if (obs !== m) begin errors++; $display("FAIL rnd_idex[%0d]: got %h want %h", i, obs, m); end
`ifdef ID_EX_STAGE_STALL_COUNT_EN
      checks++;
      if (bubble_cnt !== 16'(mcnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, bubble_cnt, mcnt); end
`endif
    end
    ex_flush = 1'b0; mem_hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_unused();
    test_r0();
    test_flush_hazard();
    test_hold();
    test_reset_mid_bubble();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
